// File: rtl/number_glyph_renderer_if.sv
// Digit-glyph request/response bundle between the time/score controllers
// (master) and the glyph renderer (slave).
//   selected_number : digit 0-9 to draw
//   glyph_count     : in-glyph address, row*10+col, legal 0-99
//   en              : request valid this cycle
//   pixel_valid     : pixel_rgb belongs to a glyph request
//   pixel_on        : looked-up font bit is lit
//   pixel_rgb       : RGB444 pixel colour
interface number_glyph_renderer_if;
    logic [3:0]  selected_number;
    logic [7:0]  glyph_count;
    logic        en;
    logic        pixel_valid;
    logic        pixel_on;
    logic [11:0] pixel_rgb;

    modport master (
        output selected_number, glyph_count, en,
        input  pixel_valid, pixel_on, pixel_rgb
    );

    modport slave (
        input  selected_number, glyph_count, en,
        output pixel_valid, pixel_on, pixel_rgb
    );
endinterface

// File: rtl/number_glyph_renderer.sv
// 10x10 digit-glyph renderer: two-stage pipeline from a glyph request to a
// registered RGB444 pixel, plus a saturating count of malformed requests.
// Optional blinking is built in with the NUMBER_GLYPH_BLINK_EN macro.
// Ports:
//   clock_25      : pixel clock, rising edge
//   reset         : active-low synchronous reset
//   sync_reset    : active-high synchronous game restart
//   glyph_bus     : request in / pixel out (slave modport)
//   frame_tik     : one-cycle pulse per frame (blink phase)
//   blink_req     : request digit blinking
//   bad_req_count : saturating count of malformed requests
module number_glyph_renderer #(
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000,
    parameter int          BLINK_BIT = 4
) (
    input  logic                          clock_25,
    input  logic                          reset,
    input  logic                          sync_reset,
    number_glyph_renderer_if.slave        glyph_bus,
    input  logic                          frame_tik,
    input  logic                          blink_req,
    output logic [7:0]                    bad_req_count
);

    // One 100-bit word per digit, top row in the MSBs; within a row bit 9 is
    // the leftmost column. Columns 0 and 9 stay dark to space adjacent digits.
    function automatic logic [9:0] font_row(input logic [3:0] digit, input logic [3:0] row);
        logic [99:0] glyph;
        case (digit)
            4'd0: glyph = {10'b0011111100, 10'b0110000110, 10'b0110001110, 10'b0110010110, 10'b0110100110,
                           10'b0111000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            4'd1: glyph = {10'b0000110000, 10'b0001110000, 10'b0011110000, 10'b0000110000, 10'b0000110000,
                           10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0011111100, 10'b0000000000};
            4'd2: glyph = {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000001100, 10'b0000011000,
                           10'b0000110000, 10'b0001100000, 10'b0011000000, 10'b0111111110, 10'b0000000000};
            4'd3: glyph = {10'b0011111100, 10'b0110000110, 10'b0000000110, 10'b0000000110, 10'b0001111100,
                           10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            4'd4: glyph = {10'b0000011100, 10'b0000111100, 10'b0001101100, 10'b0011001100, 10'b0110001100,
                           10'b0111111110, 10'b0000001100, 10'b0000001100, 10'b0000001100, 10'b0000000000};
            4'd5: glyph = {10'b0111111110, 10'b0110000000, 10'b0110000000, 10'b0111111100, 10'b0000000110,
                           10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            4'd6: glyph = {10'b0011111100, 10'b0110000000, 10'b0110000000, 10'b0111111100, 10'b0110000110,
                           10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            4'd7: glyph = {10'b0111111110, 10'b0000000110, 10'b0000001100, 10'b0000011000, 10'b0000110000,
                           10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000000000};
            4'd8: glyph = {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0110000110,
                           10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            4'd9: glyph = {10'b0011111100, 10'b0110000110, 10'b0110000110, 10'b0110000110, 10'b0011111110,
                           10'b0000000110, 10'b0000000110, 10'b0110000110, 10'b0011111100, 10'b0000000000};
            default: glyph = '0;
        endcase
        // Rows 10-15 only arise from out-of-range addresses, which are dark anyway.
        if (row > 4'd9)
            return '0;
        return glyph[7'd99 - 7'(row) * 7'd10 -: 10];
    endfunction

    logic       clr;
    logic       blank_s0;
    logic [3:0] digit_s1;
    logic [3:0] row_s1;
    logic [3:0] col_s1;
    logic       valid_s1;
    logic       bad_s1;
    logic       blank_s1;
    logic [9:0] font_bits;
    logic       lit_s1;

    // reset has priority, but both sources clear to the same state.
    assign clr = !reset || sync_reset;

`ifdef NUMBER_GLYPH_BLINK_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clock_25) begin
        if (clr)
            frame_cnt <= '0;
        else if (frame_tik)
            frame_cnt <= frame_cnt + 5'd1;
    end

    assign blank_s0 = blink_req & frame_cnt[BLINK_BIT];
`else
    localparam int unused_blink_bit = BLINK_BIT;
    logic unused_blink_inputs;

    assign unused_blink_inputs = &{1'b0, frame_tik, blink_req};
    assign blank_s0 = 1'b0;
`endif

    assign font_bits = font_row(digit_s1, row_s1);
    assign lit_s1    = valid_s1 & ~bad_s1 & font_bits[4'd9 - col_s1] & ~blank_s1;

    always_ff @(posedge clock_25) begin
        if (clr) begin
            digit_s1              <= '0;
            row_s1                <= '0;
            col_s1                <= '0;
            valid_s1              <= 1'b0;
            bad_s1                <= 1'b0;
            blank_s1              <= 1'b0;
            glyph_bus.pixel_valid <= 1'b0;
            glyph_bus.pixel_on    <= 1'b0;
            glyph_bus.pixel_rgb   <= BG_COLOR;
            bad_req_count         <= '0;
        end else begin
            digit_s1 <= glyph_bus.selected_number;
            // Truncation is safe: addresses above 99 are flagged bad and never lit.
            row_s1   <= 4'(glyph_bus.glyph_count / 8'd10);
            col_s1   <= 4'(glyph_bus.glyph_count % 8'd10);
            valid_s1 <= glyph_bus.en;
            bad_s1   <= glyph_bus.en &
                        ((glyph_bus.selected_number > 4'd9) | (glyph_bus.glyph_count > 8'd99));
            blank_s1 <= blank_s0;

            glyph_bus.pixel_valid <= valid_s1;
            glyph_bus.pixel_on    <= lit_s1;
            glyph_bus.pixel_rgb   <= lit_s1 ? FG_COLOR : BG_COLOR;

            if (bad_s1 && bad_req_count != 8'hFF)
                bad_req_count <= bad_req_count + 8'd1;
        end
    end

endmodule
